// File: rtl/piso_shift_out.sv
// Parallel-in/serial-out readout: captures a word on a load strobe and streams it
// one bit per accepted valid/ready transfer, with frame_start and done delimiters.
module piso_shift_out #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load_en,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_sout_ready,
   output logic             o_sout,
   output logic             o_sout_valid,
   output logic             o_frame_start,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             r_state, w_state_nx;
   logic [WIDTH-1:0]   r_shift, w_shift_nx;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
   logic               r_sout, w_sout_nx;
   logic               r_valid, w_valid_nx;
   logic               r_fs, w_fs_nx;
   logic               r_busy, w_busy_nx;
   logic               r_done, w_done_nx;

   logic [WIDTH-1:0]   w_shifted;
   logic               w_head_d;
   logic               w_head_shifted;

   // The head bit sits at the end selected by MSB_FIRST; shifting moves the next bit there.
   assign w_shifted      = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
   assign w_head_d       = MSB_FIRST ? i_d[WIDTH-1] : i_d[0];
   assign w_head_shifted = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];

   // Handshake: a bit transfers on a rising edge where o_sout_valid=1 and i_sout_ready=1;
   // while i_sout_ready=0 the presented bit, valid, frame_start and counter all hold.
   always_comb begin
      w_state_nx = r_state;
      w_shift_nx = r_shift;
      w_cnt_nx   = r_cnt;
      w_sout_nx  = r_sout;
      w_valid_nx = r_valid;
      w_fs_nx    = r_fs;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_sout_nx  = 1'b0;
            w_valid_nx = 1'b0;
            w_fs_nx    = 1'b0;
            w_busy_nx  = 1'b0;
            if (i_load_en) begin
               w_state_nx = ST_SHIFT;
               w_shift_nx = i_d;
               w_cnt_nx   = CNT_W'(WIDTH - 1);
               w_sout_nx  = w_head_d;
               w_valid_nx = 1'b1;
               w_fs_nx    = 1'b1;
               w_busy_nx  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (i_sout_ready) begin
               if (r_cnt != '0) begin
                  w_shift_nx = w_shifted;
                  w_cnt_nx   = r_cnt - CNT_W'(1);
                  w_sout_nx  = w_head_shifted;
                  w_fs_nx    = 1'b0;
               end else begin
                  w_state_nx = ST_IDLE;
                  w_sout_nx  = 1'b0;
                  w_valid_nx = 1'b0;
                  w_fs_nx    = 1'b0;
                  w_busy_nx  = 1'b0;
                  w_done_nx  = 1'b1;
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_sout  <= 1'b0;
         r_valid <= 1'b0;
         r_fs    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_shift <= w_shift_nx;
         r_cnt   <= w_cnt_nx;
         r_sout  <= w_sout_nx;
         r_valid <= w_valid_nx;
         r_fs    <= w_fs_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
      end
   end

   assign o_sout        = r_sout;
   assign o_sout_valid  = r_valid;
   assign o_frame_start = r_fs;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_dbg_state   = r_state;

endmodule
